// File: rtl/pc_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_if
// Brief    : Fetch-stage program counter control bundle: execute-stage
//            redirect/stall controls in, fetch address out.
// Revision : 1.0 - initial release
// ============================================================================
interface pc_if;
  logic        stall;
  logic [1:0]  jmp_op;
  logic [31:0] next_addr;
  logic        valid;
  logic        cmp;
  logic        fault;
  logic [31:0] addr;

  // Control source (execute stage) drives controls and observes the PC.
  modport master (
    output stall, jmp_op, next_addr, valid, cmp, fault,
    input  addr
  );

  // Program counter consumes controls and drives the fetch address.
  modport slave (
    input  stall, jmp_op, next_addr, valid, cmp, fault,
    output addr
  );
endinterface
`default_nettype wire

// File: rtl/pc.sv
`default_nettype none
// ============================================================================
// Module   : pc
// Brief    : Program counter for the fetch stage. Holds, increments by 4,
//            loads a jump/branch target, or redirects to a trap vector.
// Revision : 1.0 - initial release
// ============================================================================
module pc #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] TRAP_ADDR  = 32'h0000_0000
) (
  input  wire logic clk,
  input  wire logic rst,
  pc_if.slave       bus
);

  localparam logic [31:0] INCR = 32'd4;

  // Declaration initialiser gives the power-up value before any reset.
  logic [31:0] pc_q = RESET_ADDR;
  logic [31:0] pc_d;
  logic        taken;
  logic        misaligned;

  // Decode jump request and pick the next PC by priority.
  always_comb begin
    taken      = 1'b0;
    misaligned = 1'b0;
    pc_d       = pc_q + INCR;

    taken = bus.valid &
            ((bus.jmp_op == 2'd1) | ((bus.jmp_op == 2'd2) & bus.cmp));
    misaligned = taken & (bus.next_addr[1:0] != 2'b00);

    if (bus.fault) begin
      pc_d = TRAP_ADDR;
    end else if (misaligned) begin
      pc_d = TRAP_ADDR;
    end else if (taken) begin
      pc_d = bus.next_addr;
    end else if (bus.stall) begin
      pc_d = pc_q;
    end
  end

  // PC register; reset wins over every other request.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_ADDR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign bus.addr = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_pc.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc
// Brief    : Scoreboard bench for pc. A default-parameter instance and a
//            second instance with distinct reset/trap vectors share stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc;

  localparam logic [31:0] R2 = 32'h0000_0100;
  localparam logic [31:0] T2 = 32'h0000_0200;

  typedef struct {
    string       tag;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  pc_if bus_a ();
  pc_if bus_b ();

  pc dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  pc #(
    .RESET_ADDR (R2),
    .TRAP_ADDR  (T2)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        exp_q[$];
  logic [31:0] mdl_a = 32'h0;
  logic [31:0] mdl_b = R2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(
    input logic [31:0] cur, input logic r, input logic f, input logic s,
    input logic v, input logic [1:0] op, input logic c, input logic [31:0] na,
    input logic [31:0] rv, input logic [31:0] tv);
    logic tk;
    tk = v && ((op == 2'd1) || (op == 2'd2 && c));
    if (r) return rv;
    if (f) return tv;
    if (tk && na[1:0] != 2'b00) return tv;
    if (tk) return na;
    if (s) return cur;
    return cur + 32'd4;
  endfunction

  task automatic step(input string tag, input logic r, input logic f, input logic s,
                      input logic v, input logic [1:0] op, input logic c,
                      input logic [31:0] na);
    exp_t e;
    rst = r;
    bus_a.fault = f; bus_a.stall = s; bus_a.valid = v;
    bus_a.jmp_op = op; bus_a.cmp = c; bus_a.next_addr = na;
    bus_b.fault = f; bus_b.stall = s; bus_b.valid = v;
    bus_b.jmp_op = op; bus_b.cmp = c; bus_b.next_addr = na;
    mdl_a = model(mdl_a, r, f, s, v, op, c, na, 32'h0, 32'h0);
    mdl_b = model(mdl_b, r, f, s, v, op, c, na, R2, T2);
    e.tag = tag; e.a = mdl_a; e.b = mdl_b;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'h1, 32'h0);
    end else begin
      e = exp_q.pop_front();
      check({e.tag, "_a"}, bus_a.addr, e.a);
      check({e.tag, "_b"}, bus_b.addr, e.b);
    end
  endtask

  initial begin
    logic [31:0] na;
    logic        r, f;
    #1;
    check("powerup_a", bus_a.addr, 32'h0);
    check("powerup_b", bus_b.addr, R2);

    //    tag          rst f  s  v  op    c  next_addr
    step("stall0",     0, 0, 1, 0, 2'd0, 0, 32'h0);
    step("inc4",       0, 0, 0, 0, 2'd0, 0, 32'h0);
    step("inc8",       0, 0, 0, 1, 2'd0, 0, 32'h0);
    step("jmp12",      0, 0, 0, 1, 2'd1, 0, 32'd12);
    step("bnt",        0, 0, 0, 1, 2'd2, 0, 32'd80);
    step("bt80",       0, 0, 0, 1, 2'd2, 1, 32'd80);
    step("bmis",       0, 0, 0, 1, 2'd2, 1, 32'd21);
    step("jmis",       0, 0, 0, 1, 2'd1, 0, 32'h102);
    step("stjmp",      0, 0, 1, 1, 2'd1, 0, 32'd12);
    for (int i = 0; i < 3; i++)
      step("sthold",   0, 0, 1, 0, 2'd1, 1, 32'h500);
    step("stmis",      0, 0, 1, 1, 2'd1, 0, 32'h333);
    step("nv_inc",     0, 0, 0, 0, 2'd1, 1, 32'h500);
    step("jmp40",      0, 0, 0, 1, 2'd1, 0, 32'h40);
    step("op3",        0, 0, 0, 1, 2'd3, 1, 32'h500);
    step("fault",      0, 1, 0, 1, 2'd1, 0, 32'h100);
    step("jmp_a0",     0, 0, 0, 1, 2'd1, 0, 32'hA0);
    step("rstall",     1, 1, 1, 1, 2'd1, 0, 32'h100);
    step("postrst",    0, 0, 0, 0, 2'd0, 0, 32'h0);
    step("jmpmax",     0, 0, 0, 1, 2'd1, 0, 32'hFFFF_FFFC);
    step("wrap",       0, 0, 0, 0, 2'd0, 0, 32'h0);

    for (int i = 0; i < 200; i++) begin
      na = $urandom();
      if ($urandom_range(0, 3) != 0) na[1:0] = 2'b00;
      r = ($urandom_range(0, 19) == 0);
      f = ($urandom_range(0, 9) == 0);
      step("rand", r, f, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), na);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
